// File: rtl/sa_tile_engine.sv
// Output-stationary N x N systolic matrix-multiply tile with skewed operand injection and row-by-row result drain.
// Latency: K feed beats + 2N-1 flush cycles, then one result row per c_valid_o/c_ready_i handshake.
// Backpressure: in_ready_o is high only in FEED; c_ready_i low holds c_data_o/c_row_o stable in DRAIN.
module sa_tile_engine #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int AW     = 32,
  parameter int KMAX   = 64,
  parameter int SIGNED = 1,
  localparam int KW    = $clog2(KMAX + 1),
  localparam int RW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              sa_rst_n,
  input  logic              start_i,
  input  logic [KW-1:0]     k_len_i,
  input  logic              acc_mode_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N*DW-1:0]   a_col_i,
  input  logic [N*DW-1:0]   b_row_i,
  output logic              c_valid_o,
  input  logic              c_ready_i,
  output logic [N*AW-1:0]   c_data_o,
  output logic [RW-1:0]     c_row_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int PW = 2 * DW;
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [FW-1:0] F_ONE      = FW'(1);
  localparam logic [KW-1:0] K_MAX_V    = KW'(KMAX);
  localparam logic [KW-1:0] K_ONE      = KW'(1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;

  logic            accept;
  logic            start_ok;
  logic            clr_acc;
  logic [KW-1:0]   k_sat;

  logic [DW-1:0]   a_in [N];
  logic [DW-1:0]   b_in [N];
  logic [DW-1:0]   a_sk [N];
  logic [DW-1:0]   b_sk [N];
  logic [DW-1:0]   a_op [N][N];
  logic [DW-1:0]   b_op [N][N];
  logic [AW-1:0]   acc  [N][N];

  logic [RW-1:0]   row_sel;
  logic [N*AW-1:0] row_dat;

  assign accept   = in_valid_i && in_ready_o;
  assign start_ok = (state == S_IDLE) && start_i;
  assign clr_acc  = start_ok && !acc_mode_i;
  assign k_sat    = (k_len_i > K_MAX_V) ? K_MAX_V : k_len_i;
  assign state_o  = state;

  // Product of two operands widened to the accumulator width with the configured signedness.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [PW-1:0] ps;
    logic        [PW-1:0] pu;
    ps = PW'($signed(a)) * PW'($signed(b));
    pu = PW'(a) * PW'(b);
    if (SIGNED != 0) return AW'(ps);
    else             return AW'(pu);
  endfunction

  // Unaccepted cycles inject zeros so bubbles and flush cycles add nothing to the sums.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = accept ? a_col_i[i*DW +: DW] : '0;
      b_in[i] = accept ? b_row_i[i*DW +: DW] : '0;
    end
  end

  // Row i of A and column i of B enter through i delay stages so wavefronts meet diagonally.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_sk[0] = a_in[0];
      assign b_sk[0] = b_in[0];
    end else begin : g_dly
      logic [DW-1:0] a_sr [gi];
      logic [DW-1:0] b_sr [gi];
      // Shift the operand through gi skew registers.
      always_ff @(posedge clk or negedge sa_rst_n) begin
        if (!sa_rst_n) begin
          for (int s = 0; s < gi; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_in[gi];
          b_sr[0] <= b_in[gi];
          for (int s = 1; s < gi; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_sk[gi] = a_sr[gi-1];
      assign b_sk[gi] = b_sr[gi-1];
    end
  end

  // PE grid: A travels east and B travels south one PE per cycle; each PE accumulates a*b.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic [AW-1:0] acc_q;

      if (gj == 0) begin : g_a_edge
        assign a_op[gi][0] = a_sk[gi];
      end else begin : g_a_pass
        logic [DW-1:0] a_q;
        // Forward A from the western neighbour.
        always_ff @(posedge clk or negedge sa_rst_n) begin
          if (!sa_rst_n) a_q <= '0;
          else           a_q <= a_op[gi][gj-1];
        end
        assign a_op[gi][gj] = a_q;
      end

      if (gi == 0) begin : g_b_edge
        assign b_op[0][gj] = b_sk[gj];
      end else begin : g_b_pass
        logic [DW-1:0] b_q;
        // Forward B from the northern neighbour.
        always_ff @(posedge clk or negedge sa_rst_n) begin
          if (!sa_rst_n) b_q <= '0;
          else           b_q <= b_op[gi-1][gj];
        end
        assign b_op[gi][gj] = b_q;
      end

      // Accumulate every cycle; a fresh run without acc_mode clears first.
      always_ff @(posedge clk or negedge sa_rst_n) begin
        if (!sa_rst_n)    acc_q <= '0;
        else if (clr_acc) acc_q <= '0;
        else              acc_q <= acc_q + mul_ext(a_op[gi][gj], b_op[gi][gj]);
      end
      assign acc[gi][gj] = acc_q;
    end
  end

  // Select the row to load into the output register next: row 0 on DRAIN entry, else the following row.
  always_comb begin
    row_sel = '0;
    if (state == S_DRAIN && c_row_o != ROW_LAST) row_sel = c_row_o + ROW_ONE;
    row_dat = '0;
    for (int j = 0; j < N; j++) row_dat[j*AW +: AW] = acc[row_sel][j];
  end

  // Control FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or negedge sa_rst_n) begin
    if (!sa_rst_n) begin
      state      <= S_IDLE;
      k_reg      <= '0;
      beat_cnt   <= '0;
      flush_cnt  <= '0;
      in_ready_o <= 1'b0;
      c_valid_o  <= 1'b0;
      c_data_o   <= '0;
      c_row_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            busy_o    <= 1'b1;
            k_reg     <= k_sat;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            if (k_sat == '0) begin
              // Nothing to feed: present the (possibly just cleared) accumulators directly.
              state     <= S_DRAIN;
              c_valid_o <= 1'b1;
              c_row_o   <= '0;
              c_data_o  <= acc_mode_i ? row_dat : '0;
            end else begin
              state      <= S_FEED;
              in_ready_o <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + K_ONE;
            if (beat_cnt == k_reg - K_ONE) begin
              state      <= S_FLUSH;
              in_ready_o <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state     <= S_DRAIN;
            c_valid_o <= 1'b1;
            c_row_o   <= '0;
            c_data_o  <= row_dat;
          end else begin
            flush_cnt <= flush_cnt + F_ONE;
          end
        end
        S_DRAIN: begin
          if (c_ready_i) begin
            if (c_row_o == ROW_LAST) begin
              state     <= S_DONE;
              c_valid_o <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              c_row_o  <= c_row_o + ROW_ONE;
              c_data_o <= row_dat;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          in_ready_o <= 1'b0;
          c_valid_o  <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sa_tile_engine.md
SA_TILE_ENGINE -- requirements
Module: sa_tile_engine

Interface
REQ-001 SHALL have parameter N, default 4: array dimension, N x N PEs; legal range 2..16.
REQ-002 SHALL have parameter DW, default 8: operand width.
REQ-003 SHALL have parameter AW, default 32: accumulator and result width.
REQ-004 SHALL have parameter KMAX, default 64: maximum inner dimension per run.
REQ-005 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port sa_rst_n  in  1: asynchronous, active-low reset.
REQ-008 SHALL have port start_i  in  1: start a run; sampled only in IDLE.
REQ-009 SHALL have port k_len_i  in  clog2(KMAX+1): inner dimension K, captured at start.
REQ-010 SHALL have port acc_mode_i  in  1: captured at start; 0 = clear accumulators, 1 = accumulate onto previous results.
REQ-011 SHALL have port in_valid_i  in  1: operand beat valid.
REQ-012 SHALL have port in_ready_o  out  1: beat accepted when in_valid_i && in_ready_o.
REQ-013 SHALL have port a_col_i  in  N*DW: column k of A; row i at bits [(i+1)*DW-1 : i*DW].
REQ-014 SHALL have port b_row_i  in  N*DW: row k of B; column j at bits [(j+1)*DW-1 : j*DW].
REQ-015 SHALL have port c_valid_o  out  1: result row valid.
REQ-016 SHALL have port c_ready_i  in  1: result consumer ready.
REQ-017 SHALL have port c_data_o  out  N*AW: result row; column j at bits [(j+1)*AW-1 : j*AW].
REQ-018 SHALL have port c_row_o  out  clog2(N): index of the current result row.
REQ-019 SHALL have port busy_o  out  1: high in any state other than IDLE.
REQ-020 SHALL have port done_o  out  1: one-cycle completion pulse.
REQ-021 SHALL have port state_o  out  3: FSM state encoding, for debug.

Function
REQ-022 SHALL implement FSM states IDLE=0, FEED=1, FLUSH=2, DRAIN=3, DONE=4.
REQ-023 IDLE -> FEED on start_i. Capture k_len_i and acc_mode_i. If acc_mode_i=0, clear all accumulators in the same cycle. Exception: if k_len_i=0, go directly to DRAIN.
REQ-024 In FEED, in_ready_o SHALL be 1. Outside FEED, in_ready_o SHALL be 0.
REQ-025 Each accepted beat increments the beat counter. FEED -> FLUSH on the cycle the K-th beat is accepted.
REQ-026 Row-i A operands and column-j B operands SHALL be skewed internally by i and j register stages respectively. Operands then propagate one PE per cycle, east (A) and south (B).
REQ-027 Any cycle with no accepted beat, and every cycle in FLUSH, SHALL inject zero operands. Bubbles therefore do not change results.
REQ-028 Each PE(i,j) SHALL update acc <= acc + a*b every cycle.
REQ-029 The product SHALL be 2*DW bits, sign- or zero-extended to AW bits according to SIGNED; the sum wraps modulo 2^AW.
REQ-030 FLUSH SHALL last exactly 2N-1 cycles, then go to DRAIN. This ensures PE(N-1,N-1) has absorbed the final beat.
REQ-031 In DRAIN, rows 0..N-1 SHALL be presented in order with c_valid_o=1, and c_row_o SHALL equal the row index.
REQ-032 The row advances only on c_valid_o && c_ready_i.
REQ-033 While c_valid_o && !c_ready_i, c_data_o and c_row_o SHALL hold stable.
REQ-034 DRAIN -> DONE on the handshake of row N-1.
REQ-035 DONE SHALL assert done_o for one cycle, then go to IDLE.
REQ-036 Accumulators SHALL retain their values in IDLE so that acc_mode_i=1 can extend them.
REQ-037 start_i asserted outside IDLE SHALL be ignored.
REQ-038 k_len_i > KMAX SHALL be saturated to KMAX.
REQ-039 Outputs SHALL be registered. c_valid_o SHALL be 0 outside DRAIN.

Reset
REQ-040 On sa_rst_n=0, asynchronously and at any time including mid-run:
- state = IDLE;
- all accumulators, skew registers and counters = 0;
- in_ready_o = 0, c_valid_o = 0, done_o = 0, busy_o = 0;
- c_data_o = 0, c_row_o = 0.
REQ-041 After reset release, the first start_i SHALL behave as a fresh run.

Verification
REQ-042 N=4, SIGNED=1, acc_mode=0, K=4, A=identity, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> c_data rows equal B rows. done_o pulses one cycle after the row-3 handshake.
REQ-043 A all 0xFF (-1), B all 0x02, K=4 -> every element 0xFFFFFFF8. With SIGNED=0, every element = 4*255*2 = 2040.
REQ-044 Accumulate: run 1, all operands 1, K=4 -> elements 4. Run 2, acc_mode=1, same data -> elements 8. Run 3, acc_mode=0, K=0 -> all elements 0.
REQ-045 Backpressure: c_ready_i low for 3 cycles at row 1 -> c_data_o and c_row_o stable for those cycles. Rows arrive 0,1,2,3 with no loss or duplication.
REQ-046 Bubbles: in_valid_i toggling every other cycle, K=8 -> results identical to continuous feed. FLUSH lasts 7 cycles.
REQ-047 Reset asserted during FEED -> all outputs 0 in the same cycle (asynchronous), state_o=0. The next run produces correct results.
